// File: rtl/io_port_ctrl_pkg.sv
// Shared types and constants for the I/O port sequencing controller.
package io_pkg;

  localparam int NPORTS = 4;
  localparam int PSEL_W = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_IN  = 2'b01,
    WAIT_OUT = 2'b10,
    DONE     = 2'b11
  } state_e;

  // One-hot decode of a port index, used for the per-port ready/valid strobes.
  function automatic logic [NPORTS-1:0] port_onehot(input logic [PSEL_W-1:0] p);
    logic [NPORTS-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/io_port_ctrl_if.sv
// CPU request/response bus plus the four external port handshakes.
// master: the CPU and port registers; slave: the sequencing controller.
interface io_port_ctrl_if #(
  parameter int WIDTH = 8
);
  import io_pkg::*;

  logic                     cpu_in_req;
  logic                     cpu_out_req;
  logic [PSEL_W-1:0]        cpu_port;
  logic [WIDTH-1:0]         cpu_wdata;
  logic [WIDTH-1:0]         cpu_rdata;
  logic                     cpu_busy;
  logic                     cpu_done;
  logic                     cpu_err;

  logic [NPORTS*WIDTH-1:0]  in_data;
  logic [NPORTS-1:0]        in_valid;
  logic [NPORTS-1:0]        in_ready;
  logic [NPORTS*WIDTH-1:0]  out_data;
  logic [NPORTS-1:0]        out_valid;
  logic [NPORTS-1:0]        out_ready;

  modport master (
    output cpu_in_req, cpu_out_req, cpu_port, cpu_wdata,
    input  cpu_rdata, cpu_busy, cpu_done, cpu_err,
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_valid,
    output out_ready
  );

  modport slave (
    input  cpu_in_req, cpu_out_req, cpu_port, cpu_wdata,
    output cpu_rdata, cpu_busy, cpu_done, cpu_err,
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_valid,
    input  out_ready
  );

endinterface

// File: rtl/io_port_ctrl_watchdog.sv
// Clearable 8-bit wait timer; expire flags the last permitted wait cycle.
module io_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear has priority over counting.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/io_port_ctrl.sv
// Sequences single-cycle CPU IN/OUT requests into a port handshake,
// stalls the CPU while busy, aborts on timeout, owns the held output values.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input logic           clk,
  input logic           reset,
  io_port_ctrl_if.slave bus
);

  state_e                       state_q, state_d;
  logic [PSEL_W-1:0]            psel_q, psel_d;
  logic [WIDTH-1:0]             rdata_q, rdata_d;
  logic [NPORTS-1:0][WIDTH-1:0] out_data_q, out_data_d;
  logic [NPORTS-1:0]            in_ready_q, in_ready_d;
  logic [NPORTS-1:0]            out_valid_q, out_valid_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;

  logic [NPORTS-1:0][WIDTH-1:0] in_words;
  logic                         in_hs;
  logic                         out_hs;
  logic                         waiting;
  logic                         expire;

  assign in_words = bus.in_data;
  assign in_hs    = (state_q == WAIT_IN)  && bus.in_valid[psel_q];
  assign out_hs   = (state_q == WAIT_OUT) && bus.out_ready[psel_q];
  assign waiting  = (state_q == WAIT_IN)  || (state_q == WAIT_OUT);

  io_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == IDLE),
    .en    (waiting && !(in_hs || out_hs)),
    .expire(expire)
  );

  // Next-state, latched port/data and registered strobe decode.
  always_comb begin
    state_d    = state_q;
    psel_d     = psel_q;
    rdata_d    = rdata_q;
    out_data_d = out_data_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // IN wins a tie; the CPU keeps OUT asserted and it is served next.
        if (bus.cpu_in_req) begin
          psel_d  = bus.cpu_port;
          state_d = WAIT_IN;
        end else if (bus.cpu_out_req) begin
          psel_d                   = bus.cpu_port;
          out_data_d[bus.cpu_port] = bus.cpu_wdata;
          state_d                  = WAIT_OUT;
        end
      end
      WAIT_IN: begin
        if (in_hs) begin
          rdata_d = in_words[psel_q];
          state_d = DONE;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WAIT_OUT: begin
        if (out_hs) begin
          state_d = DONE;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from next state and port so they carry no
    // combinational path from in_valid or out_ready.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    in_ready_d  = (state_d == WAIT_IN)  ? port_onehot(psel_d) : '0;
    out_valid_d = (state_d == WAIT_OUT) ? port_onehot(psel_d) : '0;
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      rdata_q     <= '0;
      // NOTE: the held output values are architecturally visible, so this
      // register array is reset like any other state rather than left undefined.
      out_data_q  <= '0;
      in_ready_q  <= '0;
      out_valid_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      rdata_q     <= rdata_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_busy  = busy_q;
  assign bus.cpu_done  = done_q;
  assign bus.cpu_err   = err_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Scenario bench for io_port_ctrl: a long-timeout instance for handshakes and
// a TIMEOUT=4 instance for the abort paths; completions checked via scoreboard.
module tb_io_port_ctrl;
  import io_pkg::*;

  localparam int W        = 8;
  localparam int TO_MAIN  = 16;
  localparam int TO_SHORT = 4;

  typedef struct {
    logic         is_in;
    logic [1:0]   port;
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  io_port_ctrl_if #(.WIDTH(W)) bus  ();
  io_port_ctrl_if #(.WIDTH(W)) tbus ();

  io_port_ctrl #(.WIDTH(W), .TIMEOUT(TO_MAIN)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  io_port_ctrl #(.WIDTH(W), .TIMEOUT(TO_SHORT)) u_dut_to (
    .clk  (clk),
    .reset(reset),
    .bus  (tbus)
  );

  function automatic logic [W-1:0] word(input logic [4*W-1:0] v, input int p);
    return v[p*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completion of the main instance pops one expectation.
  always @(posedge clk) begin
    #1;
    if (reset === 1'b1 && bus.cpu_done === 1'b1) begin
      exp_t e;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: done pulse seen, expected none pending");
      end else begin
        e = sb_q.pop_front();
        if (bus.cpu_err !== e.err) begin
          bad++;
          $display("FAIL sb_err: got %b want %b", bus.cpu_err, e.err);
        end
        total++;
        if (e.is_in) begin
          if (bus.cpu_rdata !== e.data) begin
            bad++;
            $display("FAIL sb_rdata port%0d: got %h want %h", e.port, bus.cpu_rdata, e.data);
          end
        end else if (word(bus.out_data, e.port) !== e.data) begin
          bad++;
          $display("FAIL sb_out_data port%0d: got %h want %h", e.port,
                   word(bus.out_data, e.port), e.data);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    total++; if (bus.cpu_rdata !== '0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.cpu_rdata); end
    total++; if (bus.cpu_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.cpu_busy); end
    total++; if (bus.cpu_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.cpu_done); end
    total++; if (bus.cpu_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.cpu_err); end
    total++; if (bus.in_ready !== 4'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    total++; if (bus.out_valid !== 4'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    total++;
    if ({tbus.cpu_rdata, tbus.cpu_busy, tbus.cpu_done, tbus.cpu_err, tbus.in_ready,
         tbus.out_data, tbus.out_valid} !== '0) begin
      bad++; $display("FAIL rst_short_instance: outputs not all zero");
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({bus.cpu_busy, bus.cpu_done} !== 2'b00) begin
        bad++; $display("FAIL idle_cycle%0d busy/done: got %b want 00", i, {bus.cpu_busy, bus.cpu_done});
      end
    end
  endtask

  task automatic test_in_handshake();
    exp_t e;
    bus.in_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
    bus.in_valid = 4'b0100;
    bus.cpu_in_req = 1'b1;
    bus.cpu_port   = 2'd2;
    e = '{1'b1, 2'd2, 8'hA5, 1'b0};
    sb_q.push_back(e);
    tick();                                   // edge k+1
    bus.cpu_in_req = 1'b0;
    bus.cpu_port   = 2'd0;
    total++; if (bus.in_ready !== 4'b0100) begin bad++; $display("FAIL in_ready_k1: got %b want 0100", bus.in_ready); end
    total++; if (bus.cpu_busy !== 1'b1) begin bad++; $display("FAIL in_busy_k1: got %b want 1", bus.cpu_busy); end
    total++; if (bus.cpu_done !== 1'b0) begin bad++; $display("FAIL in_done_k1: got %b want 0", bus.cpu_done); end
    tick();                                   // edge k+2
    total++; if (bus.cpu_done !== 1'b1) begin bad++; $display("FAIL in_done_k2: got %b want 1", bus.cpu_done); end
    total++; if (bus.cpu_rdata !== 8'hA5) begin bad++; $display("FAIL in_rdata_k2: got %h want a5", bus.cpu_rdata); end
    total++; if (bus.in_ready !== 4'b0) begin bad++; $display("FAIL in_ready_k2: got %b want 0", bus.in_ready); end
    bus.in_valid = 4'b0;
    tick();                                   // edge k+3
    total++; if ({bus.cpu_busy, bus.cpu_done} !== 2'b00) begin bad++; $display("FAIL in_idle_k3: got %b want 00", {bus.cpu_busy, bus.cpu_done}); end
    total++; if (bus.cpu_rdata !== 8'hA5) begin bad++; $display("FAIL in_rdata_hold: got %h want a5", bus.cpu_rdata); end
  endtask

  task automatic test_out_late_ready();
    exp_t e;
    bus.out_ready   = 4'b0;
    bus.cpu_out_req = 1'b1;
    bus.cpu_port    = 2'd1;
    bus.cpu_wdata   = 8'h3C;
    e = '{1'b0, 2'd1, 8'h3C, 1'b0};
    sb_q.push_back(e);
    tick();                                   // edge k+1
    bus.cpu_out_req = 1'b0;
    bus.cpu_port    = 2'd3;                   // must be ignored while waiting
    bus.cpu_wdata   = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bus.out_valid, bus.cpu_done} !== 5'b0010_0) begin
        bad++; $display("FAIL out_wait%0d valid/done: got %b want 00100", i, {bus.out_valid, bus.cpu_done});
      end
      if (i == 4) bus.out_ready = 4'b0010;
      tick();
    end
    total++; if ({bus.cpu_done, bus.cpu_err} !== 2'b10) begin bad++; $display("FAIL out_done: got %b want 10", {bus.cpu_done, bus.cpu_err}); end
    total++; if (bus.out_valid !== 4'b0) begin bad++; $display("FAIL out_valid_done: got %b want 0", bus.out_valid); end
    bus.out_ready = 4'b0;
    repeat (3) tick();
    total++; if (bus.out_data !== {8'h00, 8'h00, 8'h3C, 8'h00}) begin bad++; $display("FAIL out_data_hold: got %h want 00003c00", bus.out_data); end
    total++; if (bus.cpu_busy !== 1'b0) begin bad++; $display("FAIL out_idle: got %b want 0", bus.cpu_busy); end
  endtask

  // One-cycle request on the short-timeout instance; returns at edge k+1.
  task automatic to_issue(input logic is_in, input logic [1:0] p, input logic [W-1:0] wd);
    tbus.cpu_in_req  = is_in;
    tbus.cpu_out_req = !is_in;
    tbus.cpu_port    = p;
    tbus.cpu_wdata   = wd;
    tick();
    tbus.cpu_in_req  = 1'b0;
    tbus.cpu_out_req = 1'b0;
  endtask

  task automatic test_timeout();
    tbus.in_data   = {8'h00, 8'h00, 8'h00, 8'h5A};
    tbus.in_valid  = 4'b0001;
    tbus.out_ready = 4'b0;
    to_issue(1'b1, 2'd0, 8'h00);
    tick();
    total++; if ({tbus.cpu_done, tbus.cpu_rdata} !== {1'b1, 8'h5A}) begin bad++; $display("FAIL to_preload: got %b/%h want 1/5a", tbus.cpu_done, tbus.cpu_rdata); end
    tbus.in_valid = 4'b0;
    tick();
    // IN to port 3 never answered: done+err at edge k+5
    to_issue(1'b1, 2'd3, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({tbus.cpu_busy, tbus.cpu_done} !== 2'b10) begin bad++; $display("FAIL to_in_wait%0d: got %b want 10", i, {tbus.cpu_busy, tbus.cpu_done}); end
    end
    tick();
    total++; if ({tbus.cpu_done, tbus.cpu_err} !== 2'b11) begin bad++; $display("FAIL to_in_abort: got %b want 11", {tbus.cpu_done, tbus.cpu_err}); end
    total++; if (tbus.cpu_rdata !== 8'h5A) begin bad++; $display("FAIL to_in_rdata: got %h want 5a", tbus.cpu_rdata); end
    tick();
    total++; if ({tbus.cpu_done, tbus.cpu_err} !== 2'b00) begin bad++; $display("FAIL to_in_pulse: got %b want 00", {tbus.cpu_done, tbus.cpu_err}); end
    // Handshake in the expiring cycle wins without error
    to_issue(1'b1, 2'd3, 8'h00);
    repeat (3) tick();
    tbus.in_data  = {8'hC7, 8'h00, 8'h00, 8'h5A};
    tbus.in_valid = 4'b1000;
    tick();
    total++; if ({tbus.cpu_done, tbus.cpu_err} !== 2'b10) begin bad++; $display("FAIL to_tie: got %b want 10", {tbus.cpu_done, tbus.cpu_err}); end
    total++; if (tbus.cpu_rdata !== 8'hC7) begin bad++; $display("FAIL to_tie_rdata: got %h want c7", tbus.cpu_rdata); end
    tbus.in_valid = 4'b0;
    tick();
    // OUT never accepted: value stays written after abort
    to_issue(1'b0, 2'd2, 8'h9E);
    repeat (4) tick();
    total++; if ({tbus.cpu_done, tbus.cpu_err} !== 2'b11) begin bad++; $display("FAIL to_out_abort: got %b want 11", {tbus.cpu_done, tbus.cpu_err}); end
    total++; if (tbus.out_data !== {8'h00, 8'h9E, 8'h00, 8'h00}) begin bad++; $display("FAIL to_out_data: got %h want 009e0000", tbus.out_data); end
    tick();
  endtask

  task automatic test_simultaneous();
    exp_t e;
    int   dones = 0;
    int   t1    = -1;
    int   t2    = -1;
    bus.in_data    = {8'h00, 8'h00, 8'h00, 8'h66};
    bus.in_valid   = 4'b0001;
    bus.out_ready  = 4'b0001;
    bus.cpu_port   = 2'd0;
    bus.cpu_wdata  = 8'h81;
    bus.cpu_in_req = 1'b1;
    bus.cpu_out_req = 1'b1;
    e = '{1'b1, 2'd0, 8'h66, 1'b0};
    sb_q.push_back(e);
    e = '{1'b0, 2'd0, 8'h81, 1'b0};
    sb_q.push_back(e);
    for (int c = 1; c <= 20 && dones < 2; c++) begin
      tick();
      if (bus.cpu_done === 1'b1) begin
        dones++;
        if (dones == 1) begin t1 = c; bus.cpu_in_req = 1'b0; end
        else begin t2 = c; bus.cpu_out_req = 1'b0; end
      end
    end
    bus.cpu_in_req  = 1'b0;
    bus.cpu_out_req = 1'b0;
    total++; if (dones != 2) begin bad++; $display("FAIL sim_dones: got %0d want 2 within 20 cycles", dones); end
    total++; if (t1 != 2 || t2 != 5) begin bad++; $display("FAIL sim_timing: got %0d,%0d want 2,5", t1, t2); end
    bus.in_valid  = 4'b0;
    bus.out_ready = 4'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bus.in_valid  = 4'hF;
    bus.out_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      logic       is_in;
      logic [1:0] p;
      logic [7:0] d;
      is_in = 1'($urandom_range(0, 1));
      p     = 2'($urandom_range(0, 3));
      d     = 8'($urandom_range(0, 255));
      if (is_in) bus.in_data[p*W +: W] = d;
      bus.cpu_in_req  = is_in;
      bus.cpu_out_req = !is_in;
      bus.cpu_port    = p;
      bus.cpu_wdata   = d;
      e = '{is_in, p, d, 1'b0};
      sb_q.push_back(e);
      tick();
      bus.cpu_in_req  = 1'b0;
      bus.cpu_out_req = 1'b0;
      tick();
      total++; if (bus.cpu_done !== 1'b1) begin bad++; $display("FAIL b2b%0d_done: got %b want 1", i, bus.cpu_done); end
      tick();
    end
    bus.in_valid  = 4'b0;
    bus.out_ready = 4'b0;
  endtask

  task automatic test_mid_reset();
    bus.out_ready   = 4'b0;
    bus.cpu_out_req = 1'b1;
    bus.cpu_port    = 2'd2;
    bus.cpu_wdata   = 8'h77;
    tick();
    bus.cpu_out_req = 1'b0;
    tick();
    total++; if (bus.out_valid !== 4'b0100) begin bad++; $display("FAIL mr_wait: got %b want 0100", bus.out_valid); end
    #2 reset = 1'b0;
    #1;
    total++; if (bus.cpu_busy !== 1'b0) begin bad++; $display("FAIL mr_busy: got %b want 0", bus.cpu_busy); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL mr_out_data: got %h want 0", bus.out_data); end
    total++; if (bus.out_valid !== 4'b0) begin bad++; $display("FAIL mr_out_valid: got %b want 0", bus.out_valid); end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({bus.cpu_busy, bus.cpu_done} !== 2'b00) begin bad++; $display("FAIL mr_after%0d: got %b want 00", i, {bus.cpu_busy, bus.cpu_done}); end
    end
  endtask

  initial begin
    bus.cpu_in_req   = 1'b0;
    bus.cpu_out_req  = 1'b0;
    bus.cpu_port     = '0;
    bus.cpu_wdata    = '0;
    bus.in_data      = '0;
    bus.in_valid     = '0;
    bus.out_ready    = '0;
    tbus.cpu_in_req  = 1'b0;
    tbus.cpu_out_req = 1'b0;
    tbus.cpu_port    = '0;
    tbus.cpu_wdata   = '0;
    tbus.in_data     = '0;
    tbus.in_valid    = '0;
    tbus.out_ready   = '0;

    test_reset();
    test_in_handshake();
    test_out_late_ready();
    test_timeout();
    test_simultaneous();
    test_back_to_back();
    test_mid_reset();

    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation did not finish, required finish before 100000");
    $fatal(1, "time limit");
  end

endmodule
